instruction_issuer: RTL and testbench

- Feeds decoded-ready instructions into the core's `instructionIn`/`start`/`busy` interface from the host side.
- A host loader writes 32-bit instruction words into an internal FIFO through a valid/ready port.
- The issuer pops one word at a time, presents it to the core with a one-cycle `start` pulse, and holds it stable until the core's `busy` falls.
- It then issues the next word, counts completed instructions, and flags a core that never acknowledges.

---
 rtl/instruction_issuer_pkg.sv | 15 +
 rtl/instruction_fifo.sv | 53 +++++
 rtl/instruction_issuer.sv | 121 ++++++++++++
 tb/tb_instruction_issuer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_issuer_pkg.sv
// Shared widths, state encodings and payload type for the instruction issuer.
package instruction_issuer_pkg;

  localparam int unsigned INSTRUCTION_WIDTH  = 32;
  localparam int unsigned ISSUER_STATE_WIDTH = 2;
  localparam int unsigned COUNT_WIDTH        = 16;

  localparam logic [ISSUER_STATE_WIDTH-1:0] ST_IDLE      = 2'd0;
  localparam logic [ISSUER_STATE_WIDTH-1:0] ST_ISSUE     = 2'd1;
  localparam logic [ISSUER_STATE_WIDTH-1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [ISSUER_STATE_WIDTH-1:0] ST_WAIT_DONE = 2'd3;

  typedef logic [INSTRUCTION_WIDTH-1:0] instr_t;

endpackage

// File: rtl/instruction_fifo.sv
// Instruction word FIFO; pointers carry a wrap bit so full/empty come from a pointer compare.
module instruction_fifo
  import instruction_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  instr_t dataIn,
  output instr_t dataOut,
  output logic   empty,
  output logic   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  instr_t        r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  // Flush dominates any same-cycle push or pop.
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= dataIn;
  end

  assign dataOut = r_mem[r_rd_ptr[AW-1:0]];
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/instruction_issuer.sv
// Pops queued instruction words and hands them to the core with a start pulse,
// waiting for busy to rise and fall; counts completions and flags a silent core.
module instruction_issuer
  import instruction_issuer_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   wrValid,
  input  logic [31:0]            wrData,
  output logic                   wrReady,
  input  logic                   coreBusy,
  output logic [31:0]            instructionOut,
  output logic                   start,
  output logic                   empty,
  output logic                   full,
  output logic [15:0]            issuedCount,
  output logic                   timeoutError,
  output logic                   idle
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [ISSUER_STATE_WIDTH-1:0] r_state;
  logic [ISSUER_STATE_WIDTH-1:0] w_next_state;
  logic [TW-1:0]                 r_timer;
  instr_t                        r_instr;
  logic [COUNT_WIDTH-1:0]        r_count;
  logic                          r_timeout_err;
  logic                          w_pop;
  logic                          w_timeout;
  logic                          w_done;
  logic                          w_empty;
  logic                          w_full;
  instr_t                        w_head;

  instruction_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wrValid),
    .pop     (w_pop),
    .flush   (flush),
    .dataIn  (wrData),
    .dataOut (w_head),
    .empty   (w_empty),
    .full    (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !w_empty && !coreBusy && !flush) begin
          w_next_state = ST_ISSUE;
          w_pop        = 1'b1;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // An acknowledge on the last allowed cycle still counts.
        if (coreBusy) begin
          w_next_state = ST_WAIT_DONE;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_next_state = ST_IDLE;
          w_timeout    = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!coreBusy) begin
          w_next_state = ST_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_timer <= '0;
    else if (r_state == ST_WAIT_ACK) r_timer <= r_timer + TW'(1);
    else                             r_timer <= '0;
  end

  // Datapath: held instruction, completion counter, sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr       <= '0;
      r_count       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_pop)  r_instr <= w_head;
      if (w_done) r_count <= r_count + COUNT_WIDTH'(1);
      if (flush)          r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign instructionOut = r_instr;
  assign start          = (r_state == ST_ISSUE);
  assign idle           = (r_state == ST_IDLE);
  assign empty          = w_empty;
  assign full           = w_full;
  assign wrReady        = !w_full;
  assign issuedCount    = r_count;
  assign timeoutError   = r_timeout_err;

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench for instruction_issuer: cycle vector table plus multi-cycle sequences.
module tb_instruction_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        wrValid = 1'b0;
  logic [31:0] wrData = '0;
  logic        drv_busy = 1'b0;
  logic        use_model = 1'b0;
  logic        model_busy = 1'b0;
  logic        coreBusy;
  logic        wrReady;
  logic [31:0] instructionOut;
  logic        start;
  logic        empty;
  logic        full;
  logic [15:0] issuedCount;
  logic        timeoutError;
  logic        idle;

  int n_err = 0;
  int n_checks = 0;
  int model_left = 0;
  int n_starts = 0;
  logic [31:0] seen [0:63];

  instruction_issuer #(.DEPTH(8), .ACK_TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .flush          (flush),
    .wrValid        (wrValid),
    .wrData         (wrData),
    .wrReady        (wrReady),
    .coreBusy       (coreBusy),
    .instructionOut (instructionOut),
    .start          (start),
    .empty          (empty),
    .full           (full),
    .issuedCount    (issuedCount),
    .timeoutError   (timeoutError),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  assign coreBusy = use_model ? model_busy : drv_busy;

  // Core model: busy rises the cycle after start is sampled and holds for 4 cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_busy <= 1'b0;
      model_left <= 0;
    end else begin
      if (model_left != 0) begin
        model_left <= model_left - 1;
        model_busy <= (model_left > 1);
      end
      if (start) begin
        model_busy <= 1'b1;
        model_left <= 4;
        seen[n_starts[5:0]] <= instructionOut;
        n_starts <= n_starts + 1;
      end
    end
  end

  typedef struct {
    logic        en, fl, wv;
    logic [31:0] wd;
    logic        busy;
    logic        st;
    logic [31:0] instr;
    logic        emp, ful;
    logic [15:0] cnt;
    logic        terr, idl;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(logic en, logic fl, logic wv, logic [31:0] wd, logic busy,
                              logic st, logic [31:0] instr, logic emp, logic ful,
                              logic [15:0] cnt, logic terr, logic idl);
    vec_t v;
    v.en = en; v.fl = fl; v.wv = wv; v.wd = wd; v.busy = busy;
    v.st = st; v.instr = instr; v.emp = emp; v.ful = ful;
    v.cnt = cnt; v.terr = terr; v.idl = idl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget, input string name);
    int k = 0;
    while (issuedCount != target && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(issuedCount), 32'(target));
  endtask

  task automatic write_word(input logic [31:0] d);
    wrValid = 1'b1;
    wrData  = d;
    step();
    wrValid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; enable = 1'b0; flush = 1'b0; wrValid = 1'b0; drv_busy = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s;
    logic [31:0] exp_q [8];

    vt[0]  = mk(1,0,1,32'h00A10093,0, 0,32'h00000000,0,0,16'd0,0,1);
    vt[1]  = mk(1,0,0,32'h0,0,        1,32'h00A10093,1,0,16'd0,0,0);
    vt[2]  = mk(1,0,0,32'h0,0,        0,32'h00A10093,1,0,16'd0,0,0);
    vt[3]  = mk(1,0,0,32'h0,1,        0,32'h00A10093,1,0,16'd0,0,0);
    vt[4]  = mk(1,0,0,32'h0,1,        0,32'h00A10093,1,0,16'd0,0,0);
    vt[5]  = mk(1,0,0,32'h0,1,        0,32'h00A10093,1,0,16'd0,0,0);
    vt[6]  = mk(1,0,0,32'h0,1,        0,32'h00A10093,1,0,16'd0,0,0);
    vt[7]  = mk(1,0,0,32'h0,0,        0,32'h00A10093,1,0,16'd1,0,1);
    vt[8]  = mk(1,0,1,32'h11111111,0, 0,32'h00A10093,0,0,16'd1,0,1);
    vt[9]  = mk(1,0,1,32'h22222222,0, 1,32'h11111111,0,0,16'd1,0,0);
    vt[10] = mk(1,0,0,32'h0,0,        0,32'h11111111,0,0,16'd1,0,0);
    vt[11] = mk(1,0,0,32'h0,0,        0,32'h11111111,0,0,16'd1,0,0);
    vt[12] = mk(1,0,0,32'h0,0,        0,32'h11111111,0,0,16'd1,0,0);
    vt[13] = mk(1,0,0,32'h0,0,        0,32'h11111111,0,0,16'd1,0,0);
    vt[14] = mk(1,0,0,32'h0,0,        0,32'h11111111,0,0,16'd1,1,1);
    vt[15] = mk(1,0,0,32'h0,0,        1,32'h22222222,1,0,16'd1,1,0);
    vt[16] = mk(1,0,0,32'h0,0,        0,32'h22222222,1,0,16'd1,1,0);
    vt[17] = mk(1,0,0,32'h0,1,        0,32'h22222222,1,0,16'd1,1,0);
    vt[18] = mk(1,0,0,32'h0,0,        0,32'h22222222,1,0,16'd2,1,1);
    vt[19] = mk(1,1,0,32'h0,0,        0,32'h22222222,1,0,16'd2,0,1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst.start", 32'(start), 32'd0);
    chk("rst.instr", instructionOut, 32'd0);
    chk("rst.count", 32'(issuedCount), 32'd0);
    chk("rst.terr", 32'(timeoutError), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.wrReady", 32'(wrReady), 32'd1);
    chk("rst.idle", 32'(idle), 32'd1);

    // Cycle vectors: basic issue, simultaneous push/pop, ACK timeout, flush
    for (int i = 0; i < 20; i++) begin
      enable = vt[i].en; flush = vt[i].fl; wrValid = vt[i].wv;
      wrData = vt[i].wd; drv_busy = vt[i].busy;
      step();
      chk($sformatf("v%0d.start", i), 32'(start), 32'(vt[i].st));
      chk($sformatf("v%0d.instr", i), instructionOut, vt[i].instr);
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vt[i].emp));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(vt[i].ful));
      chk($sformatf("v%0d.wrReady", i), 32'(wrReady), 32'(!vt[i].ful));
      chk($sformatf("v%0d.count", i), 32'(issuedCount), 32'(vt[i].cnt));
      chk($sformatf("v%0d.terr", i), 32'(timeoutError), 32'(vt[i].terr));
      chk($sformatf("v%0d.idle", i), 32'(idle), 32'(vt[i].idl));
    end
    flush = 1'b0;

    // Fill / backpressure
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_word(32'hA0000000 + 32'(i));
      if (i == 6) chk("fill.full7", 32'(full), 32'd0);
      if (i >= 7) begin
        chk($sformatf("fill.full%0d", i + 1), 32'(full), 32'd1);
        chk($sformatf("fill.wrReady%0d", i + 1), 32'(wrReady), 32'd0);
      end
    end
    base_s = n_starts;
    enable = 1'b1;
    wait_count(16'd8, 200, "fill.count");
    step();
    enable = 1'b0;
    chk("fill.starts", 32'(n_starts - base_s), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fill.order%0d", i), seen[6'(base_s + i)], 32'hA0000000 + 32'(i));
    chk("fill.empty", 32'(empty), 32'd1);

    // Simultaneous push/pop with three words queued
    write_word(32'hB0000000);
    write_word(32'hB0000001);
    write_word(32'hB0000002);
    base_s = n_starts;
    enable = 1'b1; wrValid = 1'b1; wrData = 32'hB0000003;
    step();
    enable = 1'b0; wrValid = 1'b0;
    chk("pp.start", 32'(start), 32'd1);
    chk("pp.instr", instructionOut, 32'hB0000000);
    wait_count(16'd9, 50, "pp.count1");
    for (int i = 0; i < 5; i++) begin
      write_word(32'hC0000000 + 32'(i));
      if (i == 3) chk("pp.notfull", 32'(full), 32'd0);
      if (i == 4) chk("pp.full", 32'(full), 32'd1);
    end
    exp_q = '{32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hC0000000,
              32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
    enable = 1'b1;
    wait_count(16'd17, 200, "pp.count2");
    step();
    enable = 1'b0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("pp.order%0d", i), seen[6'(base_s + 1 + i)], exp_q[i]);

    // Enable dropped during WAIT_DONE with two words still queued
    write_word(32'hD0000000);
    write_word(32'hD0000001);
    write_word(32'hD0000002);
    base_s = n_starts;
    enable = 1'b1;
    repeat (3) step();
    chk("en.busy_state", 32'(idle), 32'd0);
    enable = 1'b0;
    repeat (12) step();
    chk("en.count", 32'(issuedCount), 32'd18);
    chk("en.starts", 32'(n_starts - base_s), 32'd1);
    chk("en.idle", 32'(idle), 32'd1);
    chk("en.empty", 32'(empty), 32'd0);
    chk("en.instr", instructionOut, 32'hD0000000);
    enable = 1'b1;
    wait_count(16'd20, 100, "en.count2");
    step();
    enable = 1'b0;
    chk("en.order1", seen[6'(base_s + 1)], 32'hD0000001);
    chk("en.order2", seen[6'(base_s + 2)], 32'hD0000002);

    // Asynchronous reset in WAIT_DONE
    write_word(32'hE0000000);
    write_word(32'hE0000001);
    enable = 1'b1;
    repeat (3) step();
    chk("ar.pre_idle", 32'(idle), 32'd0);
    chk("ar.pre_instr", instructionOut, 32'hE0000000);
    #3;
    reset = 1'b0;
    #1;
    chk("ar.start", 32'(start), 32'd0);
    chk("ar.instr", instructionOut, 32'd0);
    chk("ar.empty", 32'(empty), 32'd1);
    chk("ar.count", 32'(issuedCount), 32'd0);
    chk("ar.idle", 32'(idle), 32'd1);
    chk("ar.full", 32'(full), 32'd0);
    chk("ar.terr", 32'(timeoutError), 32'd0);
    step();
    reset = 1'b1;
    repeat (4) step();
    chk("ar.post_idle", 32'(idle), 32'd1);
    chk("ar.post_instr", instructionOut, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
